// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encoding and default instruction constants
//
// Purpose : shared types for the JTAG TAP controller.
//   tap_state_e      4-bit TAP state, TEST_LOGIC_RESET = 4'h0
//   TAP_IR_WIDTH     default instruction register width
//   TAP_IDCODE_INSTR default IDCODE instruction (loaded in TEST_LOGIC_RESET)
//   TAP_BYPASS_INSTR default BYPASS instruction

package tap_pkg;

  localparam int TAP_IR_WIDTH = 4;

  localparam logic [TAP_IR_WIDTH-1:0] TAP_IDCODE_INSTR = 4'b0001;
  localparam logic [TAP_IR_WIDTH-1:0] TAP_BYPASS_INSTR = 4'b1111;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR        = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR        = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_state_e;

endpackage

// File: rtl/tap_clock_gate.sv
// rtl/tap_clock_gate.sv - glitch-free latch + AND clock gate
//
// Purpose : produce gclk = tck & en, with en captured while tck is low so
//           that en changes during the high phase can never chop a pulse.
// Ports   :
//   tck   in  source clock
//   en    in  enable, may change at any time
//   gclk  out gated clock

module tap_clock_gate (
  input  logic tck,
  input  logic en,
  output logic gclk
);

  logic en_latched;

  // Transparent while tck is low, holds across the high phase.
  always_latch begin
    if (!tck) en_latched <= en;
  end

  assign gclk = tck & en_latched;

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP state machine with instruction update register
//
// Purpose : decodes TMS into IR/DR shift, clock and update controls, and holds
//           the active instruction.
// Ports   :
//   tck          in  test clock, all state changes on posedge
//   trst_n       in  synchronous active-low reset
//   tms          in  test mode select
//   ir_p_o       in  parallel outputs of the IR cell chain
//   shift_ir     out high in SHIFT_IR
//   clock_ir     out gated tck for CAPTURE_IR/SHIFT_IR
//   shift_dr     out high in SHIFT_DR
//   clock_dr     out gated tck for CAPTURE_DR/SHIFT_DR
//   update_dr    out high in UPDATE_DR
//   select_ir    out TDO mux select, 1 = IR chain
//   tdo_en       out high in SHIFT_IR or SHIFT_DR
//   instruction  out active instruction
//   sel_bypass   out instruction == BYPASS_INSTR
//   sel_idcode   out instruction == IDCODE_INSTR
//   tap_state    out current state encoding

module tap_controller
  import tap_pkg::*;
#(
  parameter int                  IR_WIDTH     = TAP_IR_WIDTH,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = {{(IR_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = {IR_WIDTH{1'b1}}
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic [IR_WIDTH-1:0] ir_p_o,
  output logic                shift_ir,
  output logic                clock_ir,
  output logic                shift_dr,
  output logic                clock_dr,
  output logic                update_dr,
  output logic                select_ir,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] instruction,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic [3:0]          tap_state
);

  tap_state_e state;
  tap_state_e next_state;
  logic       en_ir;
  logic       en_dr;

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      state       <= TEST_LOGIC_RESET;
      instruction <= IDCODE_INSTR;
    end else begin
      state <= next_state;
      // Entering (or staying in) TLR forces IDCODE so the instruction is
      // already IDCODE on the first cycle tap_state reads TLR.
      if (next_state == TEST_LOGIC_RESET) begin
        instruction <= IDCODE_INSTR;
      end else if (state == UPDATE_IR) begin
        instruction <= ir_p_o;
      end
    end
  end

  always_comb begin
    next_state = state;
    shift_ir   = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    select_ir  = 1'b0;
    en_ir      = 1'b0;
    en_dr      = 1'b0;

    unique case (state)
      TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        next_state = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase

    shift_ir  = (state == SHIFT_IR);
    shift_dr  = (state == SHIFT_DR);
    update_dr = (state == UPDATE_DR);
    // The IR half of the diagram occupies encodings SELECT_IR..UPDATE_IR.
    select_ir = (state >= SELECT_IR);
    // trst_n gates the enables so a reset edge never clocks the cells.
    en_ir     = trst_n && (state == CAPTURE_IR || state == SHIFT_IR);
    en_dr     = trst_n && (state == CAPTURE_DR || state == SHIFT_DR);
  end

  assign tdo_en     = shift_ir | shift_dr;
  assign sel_bypass = (instruction == BYPASS_INSTR);
  assign sel_idcode = (instruction == IDCODE_INSTR);
  assign tap_state  = state;

  tap_clock_gate u_gate_ir (
    .tck  (tck),
    .en   (en_ir),
    .gclk (clock_ir)
  );

  tap_clock_gate u_gate_dr (
    .tck  (tck),
    .en   (en_dr),
    .gclk (clock_dr)
  );

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - self-checking bench for tap_controller

module tb_tap_controller;
  import tap_pkg::*;

  logic       tck;
  logic       trst_n;
  logic       tms;
  logic [3:0] ir_p_o;
  logic       shift_ir, clock_ir, shift_dr, clock_dr, update_dr;
  logic       select_ir, tdo_en, sel_bypass, sel_idcode;
  logic [3:0] instruction;
  logic [3:0] tap_state;

  tap_controller dut (
    .tck         (tck),
    .trst_n      (trst_n),
    .tms         (tms),
    .ir_p_o      (ir_p_o),
    .shift_ir    (shift_ir),
    .clock_ir    (clock_ir),
    .shift_dr    (shift_dr),
    .clock_dr    (clock_dr),
    .update_dr   (update_dr),
    .select_ir   (select_ir),
    .tdo_en      (tdo_en),
    .instruction (instruction),
    .sel_bypass  (sel_bypass),
    .sel_idcode  (sel_idcode),
    .tap_state   (tap_state)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct {
    logic       rst_n;
    logic       t;
    logic [3:0] ir;
    tap_state_e st;
    logic [3:0] instr;
    logic       cir;
    logic       cdr;
  } vec_t;

  typedef struct {
    tap_state_e st;
    logic [3:0] instr;
    logic       cir;
    logic       cdr;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb_q[$];
  tap_state_e nxt [16][2];
  tap_state_e mst;
  logic [3:0] minstr;
  bit         arc_hit [16][2];
  bit         st_hit [16];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic t, input logic [3:0] ir, input tap_state_e st,
                     input logic [3:0] instr, input logic cir, input logic cdr);
    vec_t v;
    v.rst_n = r; v.t = t; v.ir = ir; v.st = st; v.instr = instr; v.cir = cir; v.cdr = cdr;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    logic ir_side;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: empty queue at t=%0t", $time);
      return;
    end
    e = sb_q.pop_front();
    ir_side = e.st inside {SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR};
    chk("tap_state",   tap_state,   e.st);
    chk("instruction", instruction, e.instr);
    chk("clock_ir",    clock_ir,    e.cir);
    chk("clock_dr",    clock_dr,    e.cdr);
    chk("shift_ir",    shift_ir,    e.st == SHIFT_IR);
    chk("shift_dr",    shift_dr,    e.st == SHIFT_DR);
    chk("update_dr",   update_dr,   e.st == UPDATE_DR);
    chk("tdo_en",      tdo_en,      e.st == SHIFT_IR || e.st == SHIFT_DR);
    chk("select_ir",   select_ir,   ir_side);
    chk("sel_bypass",  sel_bypass,  e.instr == 4'b1111);
    chk("sel_idcode",  sel_idcode,  e.instr == 4'b0001);
  endtask

  // Inputs change 1 time unit after posedge; outputs (including the high
  // phase of the gated clocks) are sampled 1 time unit after the next posedge.
  task automatic drive(input logic r, input logic t, input logic [3:0] ir, input exp_t e);
    trst_n = r; tms = t; ir_p_o = ir;
    sb_q.push_back(e);
    @(posedge tck);
    #1;
    check_out();
  endtask

  task automatic model_step(input logic r, input logic t, input logic [3:0] ir);
    exp_t e;
    if (!r) begin
      e.st = TEST_LOGIC_RESET; e.instr = 4'b0001; e.cir = 1'b0; e.cdr = 1'b0;
    end else begin
      e.st  = nxt[mst][t];
      e.cir = (mst == CAPTURE_IR) || (mst == SHIFT_IR);
      e.cdr = (mst == CAPTURE_DR) || (mst == SHIFT_DR);
      if (e.st == TEST_LOGIC_RESET) e.instr = 4'b0001;
      else if (mst == UPDATE_IR)    e.instr = ir;
      else                          e.instr = minstr;
      arc_hit[mst][t] = 1'b1;
      st_hit[e.st]    = 1'b1;
    end
    mst = e.st; minstr = e.instr;
    drive(r, t, ir, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   arcs, sts;
    trst_n = 1'b0; tms = 1'b0; ir_p_o = 4'b0000;

    nxt[TEST_LOGIC_RESET] = '{RUN_TEST_IDLE, TEST_LOGIC_RESET};
    nxt[RUN_TEST_IDLE]    = '{RUN_TEST_IDLE, SELECT_DR};
    nxt[SELECT_DR]        = '{CAPTURE_DR,    SELECT_IR};
    nxt[CAPTURE_DR]       = '{SHIFT_DR,      EXIT1_DR};
    nxt[SHIFT_DR]         = '{SHIFT_DR,      EXIT1_DR};
    nxt[EXIT1_DR]         = '{PAUSE_DR,      UPDATE_DR};
    nxt[PAUSE_DR]         = '{PAUSE_DR,      EXIT2_DR};
    nxt[EXIT2_DR]         = '{SHIFT_DR,      UPDATE_DR};
    nxt[UPDATE_DR]        = '{RUN_TEST_IDLE, SELECT_DR};
    nxt[SELECT_IR]        = '{CAPTURE_IR,    TEST_LOGIC_RESET};
    nxt[CAPTURE_IR]       = '{SHIFT_IR,      EXIT1_IR};
    nxt[SHIFT_IR]         = '{SHIFT_IR,      EXIT1_IR};
    nxt[EXIT1_IR]         = '{PAUSE_IR,      UPDATE_IR};
    nxt[PAUSE_IR]         = '{PAUSE_IR,      EXIT2_IR};
    nxt[EXIT2_IR]         = '{SHIFT_IR,      UPDATE_IR};
    nxt[UPDATE_IR]        = '{RUN_TEST_IDLE, SELECT_DR};

    // Reset
    add(0, 0, 4'h0, TEST_LOGIC_RESET, 4'b0001, 0, 0);
    // IR load from TLR: tms 0,1,1,0,0
    add(1, 0, 4'h0, RUN_TEST_IDLE,    4'b0001, 0, 0);
    add(1, 1, 4'h0, SELECT_DR,        4'b0001, 0, 0);
    add(1, 1, 4'h0, SELECT_IR,        4'b0001, 0, 0);
    add(1, 0, 4'h0, CAPTURE_IR,       4'b0001, 0, 0);
    add(1, 0, 4'h0, SHIFT_IR,         4'b0001, 1, 0);
    // tms 0,0,0,1 -> four more IR pulses
    add(1, 0, 4'h0, SHIFT_IR,         4'b0001, 1, 0);
    add(1, 0, 4'h0, SHIFT_IR,         4'b0001, 1, 0);
    add(1, 0, 4'h0, SHIFT_IR,         4'b0001, 1, 0);
    add(1, 1, 4'h0, EXIT1_IR,         4'b0001, 1, 0);
    add(1, 1, 4'hF, UPDATE_IR,        4'b0001, 0, 0);
    add(1, 0, 4'hF, RUN_TEST_IDLE,    4'b1111, 0, 0);
    // Pause path through DR
    add(1, 1, 4'h5, SELECT_DR,        4'b1111, 0, 0);
    add(1, 0, 4'h5, CAPTURE_DR,       4'b1111, 0, 0);
    add(1, 0, 4'h5, SHIFT_DR,         4'b1111, 0, 1);
    add(1, 1, 4'h5, EXIT1_DR,         4'b1111, 0, 1);
    add(1, 0, 4'h5, PAUSE_DR,         4'b1111, 0, 0);
    add(1, 0, 4'h5, PAUSE_DR,         4'b1111, 0, 0);
    add(1, 1, 4'h5, EXIT2_DR,         4'b1111, 0, 0);
    add(1, 0, 4'h5, SHIFT_DR,         4'b1111, 0, 0);
    // Back round to SHIFT_IR
    add(1, 1, 4'h5, EXIT1_DR,         4'b1111, 0, 1);
    add(1, 1, 4'h5, UPDATE_DR,        4'b1111, 0, 0);
    add(1, 1, 4'h5, SELECT_DR,        4'b1111, 0, 0);
    add(1, 1, 4'h5, SELECT_IR,        4'b1111, 0, 0);
    add(1, 0, 4'h5, CAPTURE_IR,       4'b1111, 0, 0);
    add(1, 0, 4'h5, SHIFT_IR,         4'b1111, 1, 0);
    // Escape with tms=1 x5
    add(1, 1, 4'h5, EXIT1_IR,         4'b1111, 1, 0);
    add(1, 1, 4'h5, UPDATE_IR,        4'b1111, 0, 0);
    add(1, 1, 4'hA, SELECT_DR,        4'b1010, 0, 0);
    add(1, 1, 4'hA, SELECT_IR,        4'b1010, 0, 0);
    add(1, 1, 4'hA, TEST_LOGIC_RESET, 4'b0001, 0, 0);
    // Load 0110, re-enter SHIFT_IR, then reset mid-shift
    add(1, 0, 4'h0, RUN_TEST_IDLE,    4'b0001, 0, 0);
    add(1, 1, 4'h0, SELECT_DR,        4'b0001, 0, 0);
    add(1, 1, 4'h0, SELECT_IR,        4'b0001, 0, 0);
    add(1, 0, 4'h0, CAPTURE_IR,       4'b0001, 0, 0);
    add(1, 0, 4'h0, SHIFT_IR,         4'b0001, 1, 0);
    add(1, 1, 4'h0, EXIT1_IR,         4'b0001, 1, 0);
    add(1, 1, 4'h6, UPDATE_IR,        4'b0001, 0, 0);
    add(1, 1, 4'h6, SELECT_DR,        4'b0110, 0, 0);
    add(1, 1, 4'h6, SELECT_IR,        4'b0110, 0, 0);
    add(1, 0, 4'h6, CAPTURE_IR,       4'b0110, 0, 0);
    add(1, 0, 4'h6, SHIFT_IR,         4'b0110, 1, 0);
    add(1, 0, 4'h6, SHIFT_IR,         4'b0110, 1, 0);
    add(0, 0, 4'h6, TEST_LOGIC_RESET, 4'b0001, 0, 0);
    add(1, 1, 4'h6, TEST_LOGIC_RESET, 4'b0001, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      e.st = vecs[i].st; e.instr = vecs[i].instr; e.cir = vecs[i].cir; e.cdr = vecs[i].cdr;
      drive(vecs[i].rst_n, vecs[i].t, vecs[i].ir, e);
    end

    // Random walk against the transition table
    mst = TEST_LOGIC_RESET; minstr = 4'b0001;
    model_step(0, 0, 4'h0);
    for (int i = 0; i < 10000; i++) begin
      model_step(($urandom_range(63) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    // Five tms=1 edges reach TLR from wherever a random walk left off
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 7 + k; i++) model_step(1, 1'($urandom_range(1)), 4'($urandom_range(15)));
      for (int i = 0; i < 5; i++) model_step(1, 1, 4'($urandom_range(15)));
      chk("escape_tlr", tap_state, 4'h0);
    end

    arcs = 0; sts = 0;
    for (int s = 0; s < 16; s++) begin
      if (st_hit[s]) sts++;
      for (int t = 0; t < 2; t++) if (arc_hit[s][t]) arcs++;
    end
    chk("state_coverage", 4'(sts - 1), 4'd15);
    n_tests++;
    if (arcs != 32) begin
      n_fail++;
      $display("FAIL arc_coverage: got %0d expected 32", arcs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
